// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and rts flow-control state type
package uart_pkg;

   localparam int UART_DATA_W       = 8;
   localparam int UART_FIFO_DEPTH   = 16;
   localparam int UART_CLKS_PER_BIT = 868;

   typedef enum logic {
      RTS_ON  = 1'b0,
      RTS_OFF = 1'b1
   } rts_state_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// rtl/uart_fifo_mem.sv - simple dual-port byte storage, synchronous write, asynchronous read
module uart_fifo_mem #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [DATA_W-1:0]        wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [DATA_W-1:0]        rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receive FWFT byte buffer with rts hysteresis; UART_RX_FIFO_LEVEL_EN adds level output
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int DATA_W = UART_DATA_W,
   parameter int DEPTH  = UART_FIFO_DEPTH,
   parameter int RTS_HI = 12,
   parameter int RTS_LO = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   input  logic [DATA_W-1:0]      in_data,
   output logic                   out_valid,
   output logic [DATA_W-1:0]      out_data,
   input  logic                   out_ready,
   output logic                   rts,
   output logic                   overrun,
   input  logic                   clr_overrun
`ifdef UART_RX_FIFO_LEVEL_EN
   ,
   output logic [$clog2(DEPTH):0] level
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
   localparam logic [AW:0] HI_LVL   = (AW+1)'(RTS_HI);
   localparam logic [AW:0] LO_LVL   = (AW+1)'(RTS_LO);

   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count, count_next;
   logic          push, pop, drop;
   rts_state_t    rts_state;

   // A full FIFO still accepts a byte when a pop frees a slot in the same cycle.
   assign pop       = out_valid && out_ready;
   assign push      = in_valid && ((count < FULL_LVL) || pop);
   assign drop      = in_valid && !push;
   assign out_valid = (count != '0);

   always_comb begin
      count_next = count;
      if (push && !pop) begin
         count_next = count + 1'b1;
      end else if (pop && !push) begin
         count_next = count - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         overrun <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         count <= count_next;
         if (drop) begin
            overrun <= 1'b1;
         end else if (clr_overrun) begin
            overrun <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rts_state <= RTS_ON;
         rts       <= 1'b1;
      end else begin
         case (rts_state)
            RTS_ON: begin
               if (count_next >= HI_LVL) begin
                  rts_state <= RTS_OFF;
                  rts       <= 1'b0;
               end
            end
            RTS_OFF: begin
               if (count_next <= LO_LVL) begin
                  rts_state <= RTS_ON;
                  rts       <= 1'b1;
               end
            end
         endcase
      end
   end

   uart_fifo_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_mem (
      .clk   (clk),
      .we    (push),
      .waddr (wr_ptr),
      .wdata (in_data),
      .raddr (rd_ptr),
      .rdata (out_data)
   );

`ifdef UART_RX_FIFO_LEVEL_EN
   assign level = count;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - scoreboard bench for uart_rx_fifo against a queue reference model
module tb_uart_rx_fifo;

   localparam int DEPTH  = 16;
   localparam int RTS_HI = 12;
   localparam int RTS_LO = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic       in_valid, out_ready, clr_overrun;
   logic [7:0] in_data;
   logic       out_valid, rts, overrun;
   logic [7:0] out_data;
`ifdef UART_RX_FIFO_LEVEL_EN
   logic [4:0] level;
`endif

   uart_rx_fifo #(.DATA_W(8), .DEPTH(DEPTH), .RTS_HI(RTS_HI), .RTS_LO(RTS_LO)) dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .out_valid   (out_valid),
      .out_data    (out_data),
      .out_ready   (out_ready),
      .rts         (rts),
      .overrun     (overrun),
      .clr_overrun (clr_overrun)
`ifdef UART_RX_FIFO_LEVEL_EN
      ,
      .level       (level)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;

   logic [7:0] mq[$];
   logic [7:0] exp_q[$];
   bit  m_rts = 1'b1;
   bit  m_ovr = 1'b0;
   bit  exp_valid, exp_rts, exp_ovr;
   int  exp_cnt;
   bit  chk_en = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, req, $time);
      end
   endtask

   // One clock of stimulus; the model advances by the rules of the buffer, not its registers.
   task automatic drive(input bit iv, input logic [7:0] d, input bit rdy, input bit clr);
      bit p, q;
      @(posedge clk);
      #1;
      exp_valid = (mq.size() != 0);
      exp_rts   = m_rts;
      exp_ovr   = m_ovr;
      exp_cnt   = mq.size();
      chk_en    = 1'b1;
      in_valid    = iv;
      in_data     = d;
      out_ready   = rdy;
      clr_overrun = clr;
      p = (mq.size() > 0) && rdy;
      q = iv && ((mq.size() < DEPTH) || p);
      if (p) void'(mq.pop_front());
      if (q) begin
         mq.push_back(d);
         exp_q.push_back(d);
      end
      if (iv && !q) m_ovr = 1'b1;
      else if (clr) m_ovr = 1'b0;
      if (m_rts && mq.size() >= RTS_HI) m_rts = 1'b0;
      else if (!m_rts && mq.size() <= RTS_LO) m_rts = 1'b1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0, 1'b0);
   endtask

   task automatic pushes(input int n);
      for (int i = 0; i < n; i++) drive(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
   endtask

   task automatic pops(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b1, 1'b0);
   endtask

   always @(negedge clk) begin
      if (!reset && chk_en) begin
         chk("out_valid", out_valid, exp_valid);
         chk("rts", rts, exp_rts);
         chk("overrun", overrun, exp_ovr);
`ifdef UART_RX_FIFO_LEVEL_EN
         chk("level", level, exp_cnt);
`endif
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_err++;
               $display("FAIL out_data unexpected byte actual=%0h expected=none", out_data);
            end else begin
               chk("out_data", out_data, exp_q[0]);
               if (out_ready) void'(exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      reset = 1'b1;
      in_valid = 1'b0; in_data = '0; out_ready = 1'b0; clr_overrun = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset out_valid", out_valid, 1'b0);
      chk("reset rts", rts, 1'b1);
      chk("reset overrun", overrun, 1'b0);
      @(negedge clk);
      reset = 1'b0;

      drive(1'b1, 8'h41, 1'b0, 1'b0);
      drive(1'b1, 8'h42, 1'b0, 1'b0);
      drive(1'b1, 8'h43, 1'b0, 1'b0);
      idle(2);
      pops(4);

      pushes(12);
      idle(2);
      pops(8);
      idle(1);
      pops(1);
      idle(1);
      pops(4);

      pushes(16);
      drive(1'b1, 8'hEE, 1'b0, 1'b0);
      idle(1);
      drive(1'b0, 8'h00, 1'b0, 1'b1);
      idle(1);
      drive(1'b1, 8'hEE, 1'b0, 1'b1);
      idle(1);
      pops(17);
      drive(1'b0, 8'h00, 1'b0, 1'b1);
      idle(1);

      pushes(16);
      drive(1'b1, 8'h55, 1'b1, 1'b0);
      idle(1);
      pops(17);

      pushes(12);
      pops(7);
      idle(1);
      #2;
      reset = 1'b1;
      chk_en = 1'b0;
      in_valid = 1'b0; out_ready = 1'b0; clr_overrun = 1'b0;
      #1;
      chk("async reset out_valid", out_valid, 1'b0);
      chk("async reset rts", rts, 1'b1);
      chk("async reset overrun", overrun, 1'b0);
      mq.delete();
      exp_q.delete();
      m_rts = 1'b1;
      m_ovr = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      drive(1'b1, 8'h10, 1'b0, 1'b0);
      idle(1);
      pops(2);

      for (int i = 0; i < 1500; i++) begin
         int thr;
         thr = ((i / 100) % 2 == 0) ? 20 : 80;
         drive(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
               ($urandom_range(0, 99) < thr), ($urandom_range(0, 19) == 0));
      end
      pops(DEPTH + 2);
      idle(1);
      chk("final scoreboard empty", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end

endmodule
